// File: rtl/rr_grant_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
interface rr_grant_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );
endinterface

// File: rtl/rr_grant_arbiter8.sv
// Eight-way round-robin arbiter with bounded hold time.
// Grant index, one-hot grant and valid are all registered.
module rr_grant_arbiter8 #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input logic                 clk,
    input logic                 rst,
    rr_grant_arbiter8_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        gnt_q;
    logic              valid_q;
    logic [7:0]        others;
    logic [2:0]        nxt_ptr;

    // First set bit of vec scanning p, p+1, ... wrapping mod 8.
    function automatic logic [2:0] pick(
        input logic [7:0] vec,
        input logic [2:0] p
    );
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  off;
        dbl = {vec, vec};
        rot = dbl[p +: 8];
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        return p + off;
    endfunction

    assign others  = bus.req & ~(8'(1) << idx_q);
    assign nxt_ptr = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    idx_d   = pick(bus.req, ptr_q);
                    hold_d  = HOLD_ONE;
                end
            end
            GRANT: begin
                if (!bus.req[idx_q]) begin
                    ptr_d = nxt_ptr;
                    if (|others) begin
                        idx_d  = pick(others, nxt_ptr);
                        hold_d = HOLD_ONE;
                    end else begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_MAX && |others) begin
                    // Pre-empt the holder so waiting requesters cannot starve.
                    ptr_d  = nxt_ptr;
                    idx_d  = pick(others, nxt_ptr);
                    hold_d = HOLD_ONE;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            ptr_q   <= 3'd0;
            hold_q  <= '0;
            gnt_q   <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            valid_q <= (state_d == GRANT);
            gnt_q   <= (state_d == GRANT) ? (8'(1) << idx_d) : 8'd0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Directed vector bench for rr_grant_arbiter8 (MAX_HOLD=4).
module tb_rr_grant_arbiter8;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    rr_grant_arbiter8_if bus ();

    rr_grant_arbiter8 #(.MAX_HOLD(4), .HOLD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] g,
                           input logic [2:0] i, input logic v);
        chk({name, ".gnt"}, bus.gnt, g);
        chk({name, ".valid"}, 8'(bus.gnt_valid), 8'(v));
        if (v) chk({name, ".idx"}, 8'(bus.gnt_idx), 8'(i));
    endtask

    task automatic step(input logic [7:0] r);
        @(negedge clk);
        bus.req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        bus.req = 8'h00;

        tbl[0] = '{8'h04, 8'h04, 3'd2, 1'b1};
        tbl[1] = '{8'h00, 8'h00, 3'd0, 1'b0};
        tbl[2] = '{8'h05, 8'h01, 3'd0, 1'b1};
        tbl[3] = '{8'h08, 8'h08, 3'd3, 1'b1};
        tbl[4] = '{8'h28, 8'h08, 3'd3, 1'b1};
        tbl[5] = '{8'h20, 8'h20, 3'd5, 1'b1};
        tbl[6] = '{8'h40, 8'h40, 3'd6, 1'b1};
        tbl[7] = '{8'h81, 8'h80, 3'd7, 1'b1};
        tbl[8] = '{8'h01, 8'h01, 3'd0, 1'b1};
        tbl[9] = '{8'h00, 8'h00, 3'd0, 1'b0};

        #12;
        chk("reset.gnt", bus.gnt, 8'h00);
        chk("reset.idx", 8'(bus.gnt_idx), 8'h00);
        chk("reset.valid", 8'(bus.gnt_valid), 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Async reset in the middle of a grant
        step(8'h08);
        chk_out("pre_rst", 8'h08, 3'd3, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("mid_rst", 8'h00, 3'd0, 1'b0);
        chk("mid_rst.idx0", 8'(bus.gnt_idx), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 8'h88;
        @(posedge clk);
        #1;
        chk_out("post_rst", 8'h08, 3'd3, 1'b1);

        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].req);
            chk_out($sformatf("vec%0d", k), tbl[k].gnt, tbl[k].idx,
                    tbl[k].valid);
        end

        // Sole holder never pre-empted, then rotates once hold saturated
        for (int k = 0; k < 20; k++) begin
            step(8'h02);
            chk_out($sformatf("sole%0d", k), 8'h02, 3'd1, 1'b1);
        end
        step(8'h12);
        chk_out("sole_rot", 8'h10, 3'd4, 1'b1);
        step(8'h00);
        chk_out("sole_idle", 8'h00, 3'd0, 1'b0);

        // Full contention: each index held exactly four cycles
        do_reset();
        for (int k = 0; k < 36; k++) begin
            logic [2:0] ei;
            ei = 3'((k / 4) % 8);
            step(8'hFF);
            chk_out($sformatf("full%0d", k), 8'(1) << ei, ei, 1'b1);
            chk($sformatf("full%0d.onehot", k), 8'($onehot(bus.gnt)),
                8'h01);
        end
        step(8'h00);
        chk_out("full_idle", 8'h00, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter8.md
Name: rr_grant_arbiter8

Overview:
Round-robin arbiter that shares one resource among 8 requesters. Each cycle it keeps a single registered grant index (3 bits). It drives a one-hot 8-bit grant vector decoded from that index. It sits in front of any shared datapath addressed by a 3-to-8 one-hot select, and sequences access with a bounded hold time so that no requester starves.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant while others are pending; legal range 1..15
HOLD_W, 4, width of internal hold counter; must satisfy 2^HOLD_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock; only clock in the block
rst  input  1  asynchronous, active-high reset
req  input  8  request vector; bit i = requester i wants the resource; level-sensitive, held until done
gnt  output  8  one-hot grant; all zero when no grant; registered
gnt_idx  output  3  binary index of current grantee; registered
gnt_valid  output  1  1 when a grant is active; registered

Behaviour:
- Reset (async, rst=1, no clock needed):
  - gnt=8'b0, gnt_idx=3'd0, gnt_valid=0.
  - Internal state: priority pointer ptr=3'd0, hold_cnt=0, state=IDLE.
- Invariant: gnt = (gnt_valid ? 1<<gnt_idx : 8'b0); never more than one bit set.
- Arbitration function pick(vec, p): first set bit of vec scanning p, p+1, ..., p+7 mod 8; defined only for vec != 0.
- State IDLE (gnt_valid=0):
  - If req != 0 at a rising edge: state->GRANT, gnt_idx=pick(req, ptr), gnt_valid=1, hold_cnt=1.
  - Else remain IDLE.
  - Latency: grant appears at the first rising edge at which req is sampled nonzero (1 cycle).
- State GRANT (gnt_valid=1, current index g). Define others = req with bit g cleared. Evaluate in priority order at each edge:
  1. Release, when req[g]=0:
     - ptr=g+1 mod 8.
     - If others != 0: gnt_idx=pick(others, g+1), hold_cnt=1, stay GRANT. There is no idle bubble; gnt switches directly.
     - Else: state->IDLE, gnt_valid=0, gnt=0 on that edge.
  2. Forced rotate, when req[g]=1 and hold_cnt==MAX_HOLD and others != 0:
     - ptr=g+1 mod 8, gnt_idx=pick(others, g+1), hold_cnt=1.
     - The old grantee is pre-empted and must re-request; it is not dropped from req scanning later.
  3. Sole holder, when req[g]=1 and others == 0: keep grant; hold_cnt saturates at MAX_HOLD.
  4. Otherwise: keep grant, hold_cnt=hold_cnt+1.
- Result: with continuous contention, each grant lasts exactly MAX_HOLD cycles (fewer if released early).
- Wrap-around: ptr and pick arithmetic are mod 8 (7+1 -> 0), 3-bit natural overflow.
- Simultaneous release of g and new requests on the same edge: the new requests are arbitrated on that edge from g+1.
- req bits changing for non-granted requesters do not affect the current grant.
- MAX_HOLD=1: grant rotates every cycle under contention.
- Reset mid-grant: outputs clear immediately (asynchronously). The first post-reset grant is scanned from ptr=0.
- The state encoding is implementer's choice; the observable behaviour above is normative.

Test Plan:
1. Reset: grant active on idx 3, assert rst between edges -> gnt=8'h00, gnt_valid=0 before next edge. Release rst with req=8'h88 -> next edge gnt=8'h08, gnt_idx=3.
2. Single request: from IDLE, req=8'b00000100 -> after 1 edge gnt=8'b00000100, gnt_idx=2. Drop req -> next edge gnt=8'h00, gnt_valid=0. Then req=8'h05 -> gnt=8'h01 (ptr=3 wraps to 0).
3. Full contention, MAX_HOLD=4, req=8'hFF held -> gnt_idx sequence 0,1,2,...,7,0, each held exactly 4 cycles. gnt is always one-hot.
4. Wrap: grant on 6 released while req=8'b10000001 -> gnt=8'h80. Release 7 -> gnt=8'h01 with no zero cycle between.
5. Back-to-back handoff: gnt_idx=3, req goes from 8'b00101000 to 8'b00100000 -> next edge gnt=8'b00100000, gnt_valid stays 1.
6. Sole holder: only req[1] held for 20 cycles -> gnt=8'b00000010 throughout, no pre-emption. Assert req[4] at cycle 20 -> rotation to idx 4 on the next edge (hold_cnt saturated at MAX_HOLD).
